// File: rtl/lib_switchblock_pkg.sv
// Shared definitions for the DEM switching-block tree scheduler.
// Holds the default tree geometry, the walk state encoding and the
// PN generator constants used by the scheduler and its LFSR.
package lib_switchblock_pkg;

    localparam int LEVELS_DEF = 3;
    localparam int N_DEF      = 1 << LEVELS_DEF;
    localparam int NODES_DEF  = N_DEF - 1;
    localparam int CODE_W_DEF = LEVELS_DEF + 1;

    // Fibonacci taps for x^16+x^14+x^13+x^11+1 in the right-shifting form:
    // feedback = s[0]^s[2]^s[3]^s[5], inserted at bit 15.
    localparam logic [15:0] LFSR_TAPS   = 16'h002D;
    localparam logic [15:0] PN_SEED_DEF = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/dem_pn_lfsr.sv
// 16-bit Fibonacci LFSR that supplies the sign for odd-valued splits.
// Ports:
//   clk    - system clock
//   rst    - asynchronous active-high reset, loads SEED
//   en     - advance one step on this clock edge
//   pn_bit - current bit 0 of the register (sign source)
module dem_pn_lfsr
    import lib_switchblock_pkg::*;
#(
    parameter logic [15:0] SEED = PN_SEED_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic pn_bit
);

    logic [15:0] lfsr;
    logic        fb;

    assign fb     = ^(lfsr & LFSR_TAPS);
    assign pn_bit = lfsr[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= SEED;
        end else if (en) begin
            lfsr <= {fb, lfsr[15:1]};
        end
    end

endmodule

// File: rtl/dem_tree_scheduler.sv
// Time-multiplexed DEM switching-block tree. One accepted count is split
// node by node (breadth-first, one node per clock) through a heap-indexed
// buffer; the leaves form the unit-element enable word.
// Ports:
//   clk_i, reset_i          - clock, asynchronous active-high reset
//   x_in_i/in_valid_i/in_ready_o  - input count handshake
//   pn_en_i                 - 1: PN-randomised sign on odd splits, 0: s=+1
//   elem_o/out_valid_o/out_ready_i - element word handshake
//   busy_o                  - tree walk in progress
//   range_err_o             - one-cycle pulse when an accepted count exceeded N
module dem_tree_scheduler
    import lib_switchblock_pkg::*;
#(
    parameter int          LEVELS  = LEVELS_DEF,
    parameter int          CODE_W  = LEVELS + 1,
    parameter logic [15:0] PN_SEED = PN_SEED_DEF
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [CODE_W-1:0]       x_in_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic                    pn_en_i,
    output logic [(1<<LEVELS)-1:0]  elem_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic                    busy_o,
    output logic                    range_err_o
);

    localparam int N     = 1 << LEVELS;
    localparam int NODES = N - 1;
    localparam int BUF   = 2 * N - 1;
    localparam int IDX_W = LEVELS;

    localparam logic [CODE_W-1:0] N_CODE = CODE_W'(N);

    state_t             state;
    logic [IDX_W-1:0]   index;
    logic [CODE_W-1:0]  node [BUF];

    logic               pn_bit;
    logic               walking;
    logic               lfsr_en;
    logic [CODE_W-1:0]  v;
    logic [CODE_W-1:0]  half_up;
    logic [CODE_W-1:0]  half_dn;
    logic [CODE_W-1:0]  left;
    logic [CODE_W-1:0]  right;
    logic [IDX_W:0]     lchild;
    logic [IDX_W:0]     rchild;

    dem_pn_lfsr #(.SEED(PN_SEED)) u_lfsr (
        .clk    (clk_i),
        .rst    (reset_i),
        .en     (lfsr_en),
        .pn_bit (pn_bit)
    );

    // Shared switching block: split node[index] into its two children.
    // (v+1)/2 and (v-1)/2 for odd v; both halves equal v/2 for even v.
    always_comb begin
        walking = (state == RUN) && (32'(index) < NODES);
        v       = node[index];
        half_up = CODE_W'(({1'b0, v} + 1'b1) >> 1);
        half_dn = v >> 1;
        left    = half_dn;
        right   = half_dn;
        if (v[0]) begin
            if (!pn_en_i || pn_bit) begin
                left  = half_up;
            end else begin
                right = half_up;
            end
        end
        lfsr_en = walking && v[0] && pn_en_i;
        lchild  = {index, 1'b0} + (IDX_W+1)'(1);
        rchild  = {index, 1'b0} + (IDX_W+1)'(2);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state       <= IDLE;
            index       <= '0;
            in_ready_o  <= 1'b1;
            out_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            range_err_o <= 1'b0;
            elem_o      <= '0;
            for (int k = 0; k < BUF; k++) begin
                node[k] <= '0;
            end
        end else begin
            range_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        node[0]     <= (x_in_i > N_CODE) ? N_CODE : x_in_i;
                        range_err_o <= (x_in_i > N_CODE);
                        index       <= '0;
                        in_ready_o  <= 1'b0;
                        busy_o      <= 1'b1;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    if (walking) begin
                        node[lchild] <= left;
                        node[rchild] <= right;
                        index        <= index + 1'b1;
                    end else begin
                        // Extra cycle after the last node: leaves are settled.
                        for (int i = 0; i < N; i++) begin
                            elem_o[i] <= node[NODES + i][0];
                        end
                        busy_o      <= 1'b0;
                        out_valid_o <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        in_ready_o  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dem_tree_scheduler.sv
module tb_dem_tree_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] x_in = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       pn_en = 1'b0;
    logic [7:0] elem;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       busy;
    logic       range_err;

    int passed = 0;
    int total  = 0;

    logic [15:0] m_lfsr = 16'hACE1;

    always #5 clk = ~clk;

    dem_tree_scheduler dut (
        .clk_i       (clk),
        .reset_i     (rst),
        .x_in_i      (x_in),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .pn_en_i     (pn_en),
        .elem_o      (elem),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .busy_o      (busy),
        .range_err_o (range_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: polynomial x^16+x^14+x^13+x^11+1, shifting right.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    // Whole-sample conversion from the splitting rules; updates m_lfsr.
    function automatic logic [7:0] model(input int x, input bit pn);
        int nd [15];
        int v;
        int s;
        logic [7:0] e;
        nd[0] = (x > 8) ? 8 : x;
        for (int k = 0; k < 7; k++) begin
            v = nd[k];
            if (v % 2 == 0) s = 0;
            else if (!pn || m_lfsr[0]) s = 1;
            else s = -1;
            if ((v % 2 == 1) && pn) m_lfsr = lfsr_step(m_lfsr);
            nd[2*k+1] = (v + s) / 2;
            nd[2*k+2] = (v - s) / 2;
        end
        for (int i = 0; i < 8; i++) e[i] = (nd[7+i] == 1);
        return e;
    endfunction

    // Called at posedge+1. Runs one full sample with the given stall.
    task automatic run_sample(input int x, input bit pn, input int stall, output logic [7:0] got);
        logic [7:0] exp;
        int waitc;
        int edges;
        int sat;
        sat   = (x > 8) ? 8 : x;
        waitc = 0;
        while (!in_ready && waitc < 50) begin
            @(posedge clk); #1; waitc++;
        end
        chk("in_ready_wait", 32'(in_ready), 32'd1);
        x_in = 4'(x); pn_en = pn; in_valid = 1'b1;
        exp = model(x, pn);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("range_err", 32'(range_err), 32'(x > 8));
        chk("busy_run", 32'(busy), 32'd1);
        chk("in_ready_run", 32'(in_ready), 32'd0);
        edges = 0;
        while (!out_valid && edges < 40) begin
            @(posedge clk); #1; edges++;
            if (edges == 1) chk("range_err_pulse", 32'(range_err), 32'd0);
        end
        chk("latency", 32'(edges), 32'd8);
        chk("elem", 32'(elem), 32'(exp));
        chk("popcount", 32'($countones(elem)), 32'(sat));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk("stall_elem", 32'(elem), 32'(exp));
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        got = elem;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("post_valid", 32'(out_valid), 32'd0);
        chk("post_in_ready", 32'(in_ready), 32'd1);
        chk("post_elem_hold", 32'(elem), 32'(exp));
    endtask

    typedef struct {
        int         x;
        bit         pn;
        logic [7:0] exp_elem;
    } vec_t;

    vec_t tbl [5];

    initial begin
        logic [7:0] got;
        logic [7:0] first5;
        tbl[0] = '{x: 0,  pn: 1'b1, exp_elem: 8'h00};
        tbl[1] = '{x: 8,  pn: 1'b1, exp_elem: 8'hFF};
        tbl[2] = '{x: 5,  pn: 1'b0, exp_elem: 8'h57};
        tbl[3] = '{x: 5,  pn: 1'b0, exp_elem: 8'h57};
        tbl[4] = '{x: 12, pn: 1'b1, exp_elem: 8'hFF};

        #1 rst = 1'b1;
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_range_err", 32'(range_err), 32'd0);
        chk("rst_elem", 32'(elem), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        first5 = '0;
        for (int t = 0; t < 5; t++) begin
            run_sample(tbl[t].x, tbl[t].pn, 0, got);
            chk("table_elem", 32'(got), 32'(tbl[t].exp_elem));
            if (t == 2) first5 = got;
            if (t == 3) chk("repeat_same", 32'(got), 32'(first5));
        end

        // Streaming with downstream stalls and randomised signs.
        for (int x = 1; x <= 7; x++) begin
            run_sample(x, 1'b1, 5, got);
            chk("lfsr_nonzero", 32'(dut.u_lfsr.lfsr != 16'h0), 32'd1);
        end

        // Abort three cycles into a walk.
        x_in = 4'd6; pn_en = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_elem", 32'(elem), 32'd0);
        chk("abort_range_err", 32'(range_err), 32'd0);
        m_lfsr = 16'hACE1;
        @(posedge clk); #1;
        rst = 1'b0;
        run_sample(3, 1'b1, 0, got);
        chk("after_abort_pop", 32'($countones(got)), 32'd3);

        // Random samples against the reference model.
        for (int r = 0; r < 30; r++) begin
            run_sample(int'($urandom_range(0, 11)), 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 3)), got);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
